memory_bus_sequencer: RTL and testbench

//  Owns the single 16-bit memory bus. Arbitrates between the instruction-fetch requester
//  (PC-addressed) and the data load/store requester (MAR-addressed), and drives the memory

---
 rtl/memory_bus_sequencer_if.sv | 40 ++++
 rtl/memory_bus_sequencer.sv | 162 ++++++++++++++++
 tb/tb_memory_bus_sequencer.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_bus_sequencer_if.sv
// Signal bundle between the memory bus sequencer, its two requesters and the memory.
// The master modport is the sequencer's view; slave is the environment's view.
interface memory_bus_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              fetch_req;
  logic [ADDR_W-1:0] pc_value;
  logic              fetch_ack;
  logic [DATA_W-1:0] fetch_rdata;
  logic              data_req;
  logic              data_we;
  logic [ADDR_W-1:0] mar_value;
  logic [DATA_W-1:0] data_wdata;
  logic              data_ack;
  logic [DATA_W-1:0] data_rdata;
  logic              bus_err;
  logic              err_sticky;
  logic              addr_sel;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    input  fetch_req, pc_value, data_req, data_we, mar_value, data_wdata,
           mem_rdata, mem_ready,
    output fetch_ack, fetch_rdata, data_ack, data_rdata, bus_err, err_sticky,
           addr_sel, mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport slave (
    output fetch_req, pc_value, data_req, data_we, mar_value, data_wdata,
           mem_rdata, mem_ready,
    input  fetch_ack, fetch_rdata, data_ack, data_rdata, bus_err, err_sticky,
           addr_sel, mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface

// File: rtl/memory_bus_sequencer.sv
// Single-owner memory bus sequencer: arbitrates fetch vs. data requests, drives the
// memory strobes, counts wait states and aborts an access on timeout.
module memory_bus_sequencer #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int TIMEOUT    = 16,
  parameter int MAX_STARVE = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  memory_bus_sequencer_if.master bus
);

  localparam int WAIT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int STARVE_W = (MAX_STARVE > 0) ? $clog2(MAX_STARVE + 1) : 1;
  localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_STARVE);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH_ACC = 2'd1,
    DATA_ACC  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic [WAIT_W-1:0]   wait_r;
  logic [STARVE_W-1:0] starve_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_wdata_r;
  logic                addr_sel_r;
  logic                mem_rd_r;
  logic                mem_wr_r;
  logic                err_sticky_r;

  logic                grant_fetch_s;
  logic                grant_data_s;
  logic                done_s;
  logic                timeout_s;
  logic                fetch_ack_s;
  logic                data_ack_s;
  logic                bus_err_s;
  logic [DATA_W-1:0]   fetch_rdata_s;
  logic [DATA_W-1:0]   data_rdata_s;

  // Next-state decode: arbitration in IDLE, completion/timeout in the access states.
  always_comb begin
    next_state_s  = state_r;
    grant_fetch_s = 1'b0;
    grant_data_s  = 1'b0;
    done_s        = 1'b0;
    timeout_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.fetch_req && (!bus.data_req || (starve_r == STARVE_MAX))) begin
          grant_fetch_s = 1'b1;
          next_state_s  = FETCH_ACC;
        end else if (bus.data_req) begin
          grant_data_s = 1'b1;
          next_state_s = DATA_ACC;
        end else begin
          next_state_s = IDLE;
        end
      end
      FETCH_ACC, DATA_ACC: begin
        if (bus.mem_ready) begin
          done_s       = 1'b1;
          next_state_s = IDLE;
        end else if (wait_r == WAIT_LAST) begin
          timeout_s    = 1'b1;
          next_state_s = IDLE;
        end else begin
          next_state_s = state_r;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Acks and read data are combinational so the requester sees them in the completing cycle.
  always_comb begin
    fetch_ack_s   = 1'b0;
    data_ack_s    = 1'b0;
    bus_err_s     = 1'b0;
    fetch_rdata_s = '0;
    data_rdata_s  = '0;
    if (!reset && (done_s || timeout_s)) begin
      fetch_ack_s   = (state_r == FETCH_ACC) && bus.fetch_req;
      data_ack_s    = (state_r == DATA_ACC) && bus.data_req;
      bus_err_s     = timeout_s && (fetch_ack_s || data_ack_s);
      fetch_rdata_s = (fetch_ack_s && done_s) ? bus.mem_rdata : '0;
      data_rdata_s  = (data_ack_s && done_s) ? bus.mem_rdata : '0;
    end else begin
      fetch_ack_s = 1'b0;
      data_ack_s  = 1'b0;
    end
  end

  // State, counters and the registered bus outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= IDLE;
      wait_r       <= '0;
      starve_r     <= '0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      addr_sel_r   <= 1'b0;
      mem_rd_r     <= 1'b0;
      mem_wr_r     <= 1'b0;
      err_sticky_r <= 1'b0;
    end else begin
      state_r <= next_state_s;

      if ((state_r != IDLE) && (next_state_s != IDLE)) begin
        wait_r <= wait_r + WAIT_W'(1);
      end else begin
        wait_r <= '0;
      end

      if (grant_fetch_s) begin
        mem_addr_r  <= bus.pc_value;
        mem_wdata_r <= bus.data_wdata;
        addr_sel_r  <= 1'b0;
        mem_rd_r    <= 1'b1;
        mem_wr_r    <= 1'b0;
        starve_r    <= '0;
      end else if (grant_data_s) begin
        mem_addr_r  <= bus.mar_value;
        mem_wdata_r <= bus.data_wdata;
        addr_sel_r  <= 1'b1;
        mem_rd_r    <= !bus.data_we;
        mem_wr_r    <= bus.data_we;
        // Only a data win over a waiting fetch counts toward starvation.
        if (bus.fetch_req && (starve_r != STARVE_MAX)) begin
          starve_r <= starve_r + STARVE_W'(1);
        end
      end else if (done_s || timeout_s) begin
        mem_rd_r <= 1'b0;
        mem_wr_r <= 1'b0;
      end

      if (timeout_s) begin
        err_sticky_r <= 1'b1;
      end
    end
  end

  assign bus.fetch_ack   = fetch_ack_s;
  assign bus.fetch_rdata = fetch_rdata_s;
  assign bus.data_ack    = data_ack_s;
  assign bus.data_rdata  = data_rdata_s;
  assign bus.bus_err     = bus_err_s;
  assign bus.err_sticky  = err_sticky_r;
  assign bus.addr_sel    = addr_sel_r;
  assign bus.mem_addr    = mem_addr_r;
  assign bus.mem_rd      = mem_rd_r;
  assign bus.mem_wr      = mem_wr_r;
  assign bus.mem_wdata   = mem_wdata_r;

endmodule

// File: tb/tb_memory_bus_sequencer.sv
// Directed bench for memory_bus_sequencer; acks are matched against a queue of
// expected completions pushed as each request is driven.
module tb_memory_bus_sequencer;

  logic clk;
  logic reset;

  memory_bus_sequencer_if #(.ADDR_W(16), .DATA_W(8)) bus ();

  memory_bus_sequencer #(
    .ADDR_W(16), .DATA_W(8), .TIMEOUT(16), .MAX_STARVE(3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  typedef struct {
    logic       is_data;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic d, input logic [7:0] r, input logic e);
    exp_t x;
    x.is_data = d;
    x.rdata   = r;
    x.err     = e;
    exp_q.push_back(x);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.fetch_ack || bus.data_ack) begin
      chk("sb_expected_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ack_kind", {30'd0, bus.data_ack, bus.fetch_ack}, e.is_data ? 32'd2 : 32'd1);
        chk("ack_rdata", e.is_data ? bus.data_rdata : bus.fetch_rdata, e.rdata);
        chk("ack_bus_err", bus.bus_err, e.err);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    bus.fetch_req  = 1'b0;
    bus.pc_value   = 16'h0000;
    bus.data_req   = 1'b0;
    bus.data_we    = 1'b0;
    bus.mar_value  = 16'h0000;
    bus.data_wdata = 8'h00;
    bus.mem_rdata  = 8'h00;
    bus.mem_ready  = 1'b0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    chk("rst_acks", {bus.fetch_ack, bus.data_ack, bus.bus_err, bus.err_sticky}, 32'd0);
    chk("rst_strobes", {bus.mem_rd, bus.mem_wr, bus.addr_sel}, 32'd0);
    chk("rst_addr", bus.mem_addr, 32'h0000);
    chk("rst_wdata", bus.mem_wdata, 32'h00);

    // Fetch, zero waits; mem_ready already high in IDLE must be ignored
    next_cycle();
    reset         = 1'b0;
    bus.fetch_req = 1'b1;
    bus.pc_value  = 16'h0100;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 8'h3C;
    push_exp(1'b0, 8'h3C, 1'b0);
    @(negedge clk);
    chk("f_idle_noack", bus.fetch_ack, 32'd0);
    chk("f_idle_rd", bus.mem_rd, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("f_acc_rd", bus.mem_rd, 32'd1);
    chk("f_acc_addr", bus.mem_addr, 32'h0100);
    chk("f_acc_sel", bus.addr_sel, 32'd0);
    chk("f_acc_ack", bus.fetch_ack, 32'd1);
    next_cycle();
    bus.fetch_req = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("f_turn_rd", bus.mem_rd, 32'd0);
    chk("f_turn_ack", bus.fetch_ack, 32'd0);

    // Store with three wait states
    next_cycle();
    bus.data_req   = 1'b1;
    bus.data_we    = 1'b1;
    bus.mar_value  = 16'hFF10;
    bus.data_wdata = 8'hA5;
    bus.mem_rdata  = 8'h77;
    push_exp(1'b1, 8'h77, 1'b0);
    @(negedge clk);
    chk("s_idle_wr", bus.mem_wr, 32'd0);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      bus.mem_ready = (k == 3);
      @(negedge clk);
      chk("s_wr", {bus.mem_wr, bus.mem_rd}, 32'd2);
      chk("s_sel_addr", {bus.addr_sel, bus.mem_addr}, {15'd0, 1'b1, 16'hFF10});
      chk("s_wdata", bus.mem_wdata, 32'hA5);
      chk("s_ack", bus.data_ack, 32'(k == 3));
    end
    next_cycle();
    bus.data_req  = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("s_turn_wr", bus.mem_wr, 32'd0);

    // Both requests held, zero waits: D,D,D,F,D,D,D,F with a turnaround between each
    next_cycle();
    bus.fetch_req = 1'b1;
    bus.pc_value  = 16'h0200;
    bus.data_req  = 1'b1;
    bus.data_we   = 1'b0;
    bus.mar_value = 16'h1234;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 8'h5A;
    for (int g = 0; g < 8; g++) begin
      push_exp((g % 4) != 3, 8'h5A, 1'b0);
    end
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk("arb_ack_phase", 32'(bus.fetch_ack || bus.data_ack), 32'(c % 2));
      next_cycle();
    end
    bus.fetch_req = 1'b0;
    bus.data_req  = 1'b0;
    bus.mem_ready = 1'b0;
    chk("arb_all_acked", exp_q.size(), 32'd0);

    // Load that never completes: timeout on the 16th access cycle
    @(negedge clk);
    chk("t_sticky_before", bus.err_sticky, 32'd0);
    next_cycle();
    bus.data_req  = 1'b1;
    bus.data_we   = 1'b0;
    bus.mar_value = 16'h0040;
    bus.mem_rdata = 8'hEE;
    push_exp(1'b1, 8'h00, 1'b1);
    for (int k = 0; k < 16; k++) begin
      next_cycle();
      @(negedge clk);
      chk("t_rd", bus.mem_rd, 32'd1);
      chk("t_ack_err", {bus.data_ack, bus.bus_err}, (k == 15) ? 32'd3 : 32'd0);
      chk("t_sticky_during", bus.err_sticky, 32'd0);
    end
    next_cycle();
    bus.data_req = 1'b0;
    @(negedge clk);
    chk("t_sticky_set", bus.err_sticky, 32'd1);
    chk("t_rd_drop", bus.mem_rd, 32'd0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("t_sticky_hold", bus.err_sticky, 32'd1);

    // Data request rising during a fetch waits for the next IDLE
    next_cycle();
    bus.fetch_req = 1'b1;
    bus.pc_value  = 16'h0300;
    bus.mem_rdata = 8'h11;
    push_exp(1'b0, 8'h11, 1'b0);
    push_exp(1'b1, 8'h22, 1'b0);
    next_cycle();
    bus.data_req  = 1'b1;
    bus.data_we   = 1'b0;
    bus.mar_value = 16'h0500;
    @(negedge clk);
    chk("o_fetch_first", {bus.fetch_ack, bus.data_ack, bus.addr_sel}, 32'd0);
    next_cycle();
    bus.mem_ready = 1'b1;
    @(negedge clk);
    chk("o_fetch_ack", {bus.fetch_ack, bus.data_ack}, 32'd2);
    next_cycle();
    bus.fetch_req = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("o_turn", {bus.mem_rd, bus.data_ack}, 32'd0);
    next_cycle();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 8'h22;
    @(negedge clk);
    chk("o_data_acc", {bus.mem_rd, bus.addr_sel, bus.mem_addr}, {14'd0, 2'b11, 16'h0500});
    chk("o_data_ack", bus.data_ack, 32'd1);
    next_cycle();
    bus.data_req  = 1'b0;
    bus.mem_ready = 1'b0;

    // Reset on the second wait cycle of a load: no ack, everything cleared
    next_cycle();
    bus.data_req  = 1'b1;
    bus.data_we   = 1'b0;
    bus.mar_value = 16'h0777;
    next_cycle();
    @(negedge clk);
    chk("r_first_wait_rd", bus.mem_rd, 32'd1);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("r_no_ack", bus.data_ack, 32'd0);
    next_cycle();
    reset        = 1'b0;
    bus.data_req = 1'b0;
    @(negedge clk);
    chk("r_strobes", {bus.mem_rd, bus.mem_wr, bus.addr_sel}, 32'd0);
    chk("r_outputs", {bus.data_ack, bus.fetch_ack, bus.bus_err, bus.err_sticky}, 32'd0);
    chk("r_addr", bus.mem_addr, 32'h0000);
    next_cycle();
    @(negedge clk);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
